// File: rtl/fixed_pkg.sv
// Shared types and helpers for the fixed-2-bit PE column datapath.
package fixed_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    localparam int unsigned SAT_MAX_W = 64;

    // Clamp a (width+1)-bit sum held in the low bits of value to a width-bit result.
    function automatic logic [SAT_MAX_W-1:0] sat_ext(
        input logic [SAT_MAX_W-1:0] value,
        input logic                 is_signed,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] mask;
        logic [SAT_MAX_W-1:0] smax;
        logic [SAT_MAX_W-1:0] smin;
        logic [SAT_MAX_W-1:0] top_sh;
        logic [SAT_MAX_W-1:0] msb_sh;
        logic [SAT_MAX_W-1:0] res;
        mask   = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        smax   = (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
        smin   = SAT_MAX_W'(1) << (width - 1);
        top_sh = value >> width;
        msb_sh = value >> (width - 1);
        res    = value & mask;
        if (is_signed) begin
            if (top_sh[0] != msb_sh[0]) begin
                res = top_sh[0] ? smin : smax;
            end
        end else if (top_sh[0]) begin
            res = mask;
        end
        return res;
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// Synchronous result FIFO with registered head output; push and pop may coincide even when full.
module psum_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = head_q;

    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
        // Next head is the incoming word only when it lands exactly at the new read pointer.
        if (count_d == '0) begin
            head_d = '0;
        end else if (do_push && (rd_d == wr_q)) begin
            head_d = push_data;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: rtl/fixed2_psum_drain.sv
// Column psum sink: sums NUM_PASSES beats per result with saturation, queues results for a ready/valid consumer.
module fixed2_psum_drain
    import fixed_pkg::*;
#(
    parameter int unsigned COL_WIDTH  = 11,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned NUM_PASSES = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 s_out,
    input  logic [COL_WIDTH-1:0] psum_in,
    input  logic                 psum_valid,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 sat_flag,
    output logic                 ovf_flag
);
    localparam int unsigned CNT_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    state_e               state_q, state_d;
    logic                 s_q, s_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     pass_q, pass_d;
    logic                 push_q, push_d;
    logic [ACC_WIDTH-1:0] push_data_q, push_data_d;
    logic                 sat_q, sat_d;
    logic                 ovf_q, ovf_d;

    logic [ACC_WIDTH:0]   acc_ext, psum_ext, sum;
    logic [SAT_MAX_W-1:0] sat_val;
    logic                 sat_hit;
    logic                 fifo_full, fifo_empty, pop;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign busy      = (state_q == ACCUM);
    assign sat_flag  = sat_q;
    assign ovf_flag  = ovf_q;

    always_comb begin
        acc_ext  = s_q ? {acc_q[ACC_WIDTH-1], acc_q} : {1'b0, acc_q};
        psum_ext = {{(ACC_WIDTH + 1 - COL_WIDTH){s_q & psum_in[COL_WIDTH-1]}}, psum_in};
        sum      = acc_ext + psum_ext;
        sat_val  = sat_ext(SAT_MAX_W'(sum), s_q, ACC_WIDTH);
        // A clamped result never equals the plain truncation of the sum.
        sat_hit  = (sat_val != SAT_MAX_W'(sum[ACC_WIDTH-1:0]));
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        acc_d       = acc_q;
        pass_d      = pass_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        sat_d       = sat_q;
        ovf_d       = ovf_q;
        if (push_q && fifo_full && !pop) ovf_d = 1'b1;
        if (start) begin
            state_d = ACCUM;
            s_d     = s_out;
            acc_d   = '0;
            pass_d  = '0;
            sat_d   = 1'b0;
            ovf_d   = 1'b0;
        end else if ((state_q == ACCUM) && psum_valid) begin
            if (sat_hit) sat_d = 1'b1;
            if (pass_q == CNT_W'(NUM_PASSES - 1)) begin
                push_d      = 1'b1;
                push_data_d = sat_val[ACC_WIDTH-1:0];
                acc_d       = '0;
                pass_d      = '0;
            end else begin
                acc_d  = sat_val[ACC_WIDTH-1:0];
                pass_d = pass_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= 1'b0;
            acc_q       <= '0;
            pass_q      <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            sat_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            acc_q       <= acc_d;
            pass_q      <= pass_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            sat_q       <= sat_d;
            ovf_q       <= ovf_d;
        end
    end

    psum_fifo #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
